button_conditioner: RTL and testbench

Conditions the raw push-button input of the 7-segment counter design into a clean, single-cycle count-up request. It sits directly upstream of `TOP`'s `i_countUpClicked` input. It synchronises the asynchronous pin, debounces it, and emits one pulse per press. Holding the button also generates auto-repeat pulses at a fixed rate.

---
 rtl/button_conditioner.sv | 141 ++++++++++++++
 tb/tb_button_conditioner.sv | 123 ++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, counting debouncer and a
// press/hold/auto-repeat FSM producing single-cycle count-up requests.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 4,
    parameter int REPEAT_DELAY_CYCLES  = 20,
    parameter int REPEAT_PERIOD_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_pressed,
    output logic o_clickPulse,
    output logic o_releasedPulse,
    output logic o_repeating
);

    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_LAST  = HW'((REPEAT_DELAY_CYCLES == 0) ? 0 : REPEAT_DELAY_CYCLES - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [DW-1:0] r_dbCnt;

    state_t        r_state;
    state_t        w_stateNext;
    logic [HW-1:0] r_holdCnt;
    logic [HW-1:0] w_holdNext;
    logic          w_click;
    logic          w_release;

    logic          r_pressed;
    logic          r_clickPulse;
    logic          r_releasedPulse;
    logic          r_repeating;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_dbCnt  <= '0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            // Any sample matching the accepted level restarts the run count.
            if (r_sync2 == r_stable) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_LAST) begin
                r_stable <= r_sync2;
                r_dbCnt  <= '0;
            end else begin
                r_dbCnt <= r_dbCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_holdCnt       <= '0;
            r_pressed       <= 1'b0;
            r_clickPulse    <= 1'b0;
            r_releasedPulse <= 1'b0;
            r_repeating     <= 1'b0;
        end else begin
            r_state         <= w_stateNext;
            r_holdCnt       <= w_holdNext;
            r_pressed       <= r_stable;
            r_clickPulse    <= w_click;
            r_releasedPulse <= w_release;
            r_repeating     <= (w_stateNext == ST_REPEAT);
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_holdNext  = r_holdCnt;
        w_click     = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_stable) begin
                    w_click     = 1'b1;
                    w_holdNext  = '0;
                    w_stateNext = ST_HELD;
                end
            end
            ST_HELD: begin
                // Release is checked first so it wins over a due repeat.
                if (!r_stable) begin
                    w_release   = 1'b1;
                    w_holdNext  = '0;
                    w_stateNext = ST_IDLE;
                end else if (REPEAT_DELAY_CYCLES != 0) begin
                    if (r_holdCnt == DELAY_LAST) begin
                        w_click     = 1'b1;
                        w_holdNext  = '0;
                        w_stateNext = ST_REPEAT;
                    end else begin
                        w_holdNext = r_holdCnt + 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!r_stable) begin
                    w_release   = 1'b1;
                    w_holdNext  = '0;
                    w_stateNext = ST_IDLE;
                end else if (r_holdCnt == PERIOD_LAST) begin
                    w_click    = 1'b1;
                    w_holdNext = '0;
                end else begin
                    w_holdNext = r_holdCnt + 1'b1;
                end
            end
            default: begin
                w_holdNext  = '0;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign o_pressed       = r_pressed;
    assign o_clickPulse    = r_clickPulse;
    assign o_releasedPulse = r_releasedPulse;
    assign o_repeating     = r_repeating;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at default parameters (4/20/8);
// expected output timelines are derived from the documented latencies.
module tb_button_conditioner;

    logic clk;
    logic rst;
    logic btn;
    logic pressed;
    logic click;
    logic released;
    logic repeating;

    int n_pass;
    int n_checks;

    button_conditioner #(
        .DEBOUNCE_CYCLES      (4),
        .REPEAT_DELAY_CYCLES  (20),
        .REPEAT_PERIOD_CYCLES (8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_button        (btn),
        .o_pressed       (pressed),
        .o_clickPulse    (click),
        .o_releasedPulse (released),
        .o_repeating     (repeating)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int t, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d: got %b expected %b", tag, t, obs, exp);
    endtask

    task automatic check_quiet(input string tag, input int t);
        check({tag, ".pressed"},   t, pressed,   1'b0);
        check({tag, ".click"},     t, click,     1'b0);
        check({tag, ".released"},  t, released,  1'b0);
        check({tag, ".repeating"}, t, repeating, 1'b0);
    endtask

    // Button is high for ticks 1..hold (then low), observed for 'total' ticks.
    // Click/pressed land on tick 7 after the rise; release on tick hold+7;
    // repeats at 27, 35, 43... up to but excluding the release tick.
    task automatic press(input string tag, input int hold, input int total);
        logic accept;
        logic e_press, e_click, e_rel, e_rep;
        int   rel_t;
        accept = (hold >= 4);
        rel_t  = hold + 7;
        btn = 1'b1;
        for (int t = 1; t <= total; t++) begin
            if (t == hold + 1) btn = 1'b0;
            tick();
            e_press = accept && (t >= 7) && (t < rel_t);
            e_rel   = accept && (t == rel_t);
            e_rep   = accept && (t >= 27) && (t < rel_t);
            e_click = accept && (t < rel_t) &&
                      ((t == 7) || ((t >= 27) && ((t - 27) % 8 == 0)));
            check({tag, ".pressed"},   t, pressed,   e_press);
            check({tag, ".click"},     t, click,     e_click);
            check({tag, ".released"},  t, released,  e_rel);
            check({tag, ".repeating"}, t, repeating, e_rep);
        end
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        rst      = 1'b1;
        btn      = 1'b0;
        #1;
        check_quiet("reset_async", 0);

        // Button held during reset: nothing may happen.
        btn = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check_quiet("reset_hold", t);
        end
        rst = 1'b0;
        press("after_reset", 12, 24);

        press("glitch3", 3, 14);
        press("glitch4", 4, 14);
        press("clean", 12, 24);

        // Bounce: toggle every cycle, ending low, then hold high.
        for (int t = 1; t <= 10; t++) begin
            btn = (t % 2 == 1);
            tick();
            check_quiet("bounce", t);
        end
        press("bounce_hold", 15, 26);

        press("repeat", 60, 72);

        // Held into REPEAT, then reset asynchronously between clock edges.
        press("pre_reset", 1000, 40);
        rst = 1'b1;
        #2;
        check_quiet("reset_mid_repeat", 0);
        for (int t = 1; t <= 3; t++) begin
            tick();
            check_quiet("reset_mid_hold", t);
        end
        rst = 1'b0;
        press("post_reset", 40, 52);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
